// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller and its skid buffer.
package if_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSkid,
        StDrain
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0;
    localparam int unsigned DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc/instruction holding buffer used when a fetch lands on a frozen, full slot.
module if_skid_buf
    import if_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    logic               valid_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;

    // clear (branch) beats load so a killed fetch can never land here.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= INSTR_W'(NOP);
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end else if (unload) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC sequencing, imem req/ack handshake, IF/ID slot, redirect and flush.
// Define IF_FETCH_PERF_EN to add the fetch_cnt/stall_cnt performance counters.
module if_fetch_ctrl
    import if_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt,
`endif
    output logic               flush
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               slot_valid_q, slot_valid_d;
    logic [ADDR_W-1:0]  slot_pc_q, slot_pc_d;
    logic [INSTR_W-1:0] slot_instr_q, slot_instr_d;
    logic               flush_q;
    logic               ack, consume;
    logic               skid_load, skid_unload, skid_clear, skid_valid;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [1:0]         unused_branch_lsb;

    assign unused_branch_lsb = branch_addr[1:0];
    assign ack     = imem_req & imem_ack;
    assign consume = slot_valid_q & ~freeze;
    assign pc_inc  = pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        if (branch_taken) begin
            pc_d         = {branch_addr[ADDR_W-1:2], 2'b00};
            slot_valid_d = 1'b0;
            skid_clear   = 1'b0 | 1'b1;
            // An unacked request cannot be withdrawn; wait it out in DRAIN.
            state_d      = (imem_req && !imem_ack) ? StDrain : StFetch;
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (consume) slot_valid_d = 1'b0;
                    if (ack) begin
                        pc_d = pc_inc;
                        if (!slot_valid_q || consume) begin
                            slot_valid_d = 1'b1;
                            slot_pc_d    = pc_q;
                            slot_instr_d = imem_rdata;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = StSkid;
                        end
                    end
                end
                StSkid: begin
                    if (consume && skid_valid) begin
                        slot_pc_d    = skid_pc;
                        slot_instr_d = skid_instr;
                        skid_unload  = 1'b1;
                        state_d      = StFetch;
                    end
                end
                StDrain: if (ack) state_d = StFetch;
                default: state_d = StIdle;
            endcase
        end
        // The address is frozen for the whole DRAIN so the in-flight request stays stable.
        addr_d = (state_d == StDrain) ? addr_q : pc_d;
    end

    always_comb begin
        imem_req = (state_q == StFetch) || (state_q == StDrain);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= INSTR_W'(NOP);
            flush_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            flush_q      <= branch_taken;
        end
    end

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_pc   (pc_q),
        .load_instr(imem_rdata),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .instr     (skid_instr)
    );

    assign imem_addr = addr_q;
    assign if_valid  = slot_valid_q;
    assign if_pc     = slot_pc_q;
    assign if_instr  = slot_instr_q;
    assign flush     = flush_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (consume && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (slot_valid_q && freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized stream scoreboard.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, flush;
    logic [31:0] if_pc, if_instr;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   lat_cfg = 1;   // cycles a request is visible incl. the ack cycle; 0 = random 1..4
    int   wait_cnt = 0;
    int   cur_lat = 1;
    logic spur = 1'b0;   // ack driven while no request is outstanding

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Instruction memory with a per-request latency.
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) begin
            wait_cnt <= 0;
            cur_lat  <= (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end
    assign imem_ack   = imem_req ? (wait_cnt >= cur_lat - 1) : spur;
    assign imem_rdata = mem_word(imem_addr);

    if_fetch_ctrl #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .RESET_PC(32'h0),
        .PC_STEP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
`ifdef IF_FETCH_PERF_EN
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .flush       (flush)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Leaves the bench at the negedge where rst drops (DUT in IDLE).
    task automatic do_reset(input int lat);
        @(negedge clk);
        lat_cfg = lat; rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; spur = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        lat_cfg = 1; rst = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40; freeze = 1'b1; spur = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b want 0", flush); end
        branch_taken = 1'b0; freeze = 1'b0; spur = 1'b0; rst = 1'b0;
    endtask

    task automatic test_zero_wait;
        do_reset(1);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_idle_req: got %0b want 0", imem_req); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL zw_addr[%0d]: got req=%0b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
            end
            n_checks++; if (if_valid !== (k >= 1)) begin n_fail++; $display("FAIL zw_valid[%0d]: got %0b want %0b", k, if_valid, k >= 1); end
            if (k >= 1) begin
                n_checks++; if (if_pc !== 32'(4 * (k - 1)) || if_instr !== mem_word(32'(4 * (k - 1)))) begin
                    n_fail++; $display("FAIL zw_slot[%0d]: got pc=%h instr=%h want pc=%h instr=%h", k, if_pc, if_instr, 32'(4 * (k - 1)), mem_word(32'(4 * (k - 1))));
                end
            end
        end
    endtask

    task automatic test_latency;
        logic [31:0] exp_addr [7];
        logic        exp_v [7];
        exp_addr = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h8};
        exp_v    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset(3);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[k] || if_valid !== exp_v[k]) begin
                n_fail++; $display("FAIL lat[%0d]: got req=%0b addr=%h valid=%0b want req=1 addr=%h valid=%0b", k, imem_req, imem_addr, if_valid, exp_addr[k], exp_v[k]);
            end
            if (k == 3 || k == 6) begin
                n_checks++; if (if_pc !== ((k == 3) ? 32'h0 : 32'h4)) begin
                    n_fail++; $display("FAIL lat_pc[%0d]: got %h want %h", k, if_pc, (k == 3) ? 32'h0 : 32'h4);
                end
            end
        end
    endtask

    task automatic test_freeze_skid;
        do_reset(1);
        repeat (2) @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_ack !== 1'b1) begin
            n_fail++; $display("FAIL skid_pre: got valid=%0b pc=%h ack=%0b want 1 0 1", if_valid, if_pc, imem_ack);
        end
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
                n_fail++; $display("FAIL skid_hold[%0d]: got req=%0b valid=%0b pc=%h instr=%h want 0 1 0 %h", k, imem_req, if_valid, if_pc, if_instr, mem_word(32'h0));
            end
            if (k == 3) freeze = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== mem_word(32'(4 * k))) begin
                n_fail++; $display("FAIL skid_order[%0d]: got valid=%0b pc=%h instr=%h want 1 %h %h", k, if_valid, if_pc, if_instr, 32'(4 * k), mem_word(32'(4 * k)));
            end
            if (k == 1) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                    n_fail++; $display("FAIL skid_resume: got req=%0b addr=%h want 1 8", imem_req, imem_addr);
                end
            end
        end
    endtask

    task automatic test_branch_pending;
        int t = 0;
        do_reset(3);
        while (!(imem_req && imem_addr == 32'h20) && t < 200) begin @(negedge clk); t++; end
        n_checks++; if (t >= 200) begin n_fail++; $display("FAIL bp_reach: got timeout want addr 20"); end
        n_checks++; if (imem_ack !== 1'b0) begin n_fail++; $display("FAIL bp_pending: got ack=%0b want 0", imem_ack); end
        branch_taken = 1'b1; branch_addr = 32'h103;
        @(negedge clk);
        branch_taken = 1'b0;
        n_checks++; if (flush !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++; $display("FAIL bp_drain: got flush=%0b valid=%0b req=%0b addr=%h want 1 0 1 20", flush, if_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bp_flush_len: got %0b want 0", flush); end
        t = 0;
        while (imem_addr == 32'h20 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL bp_target: got req=%0b addr=%h want 1 100", imem_req, imem_addr);
        end
        t = 0;
        while (!if_valid && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL bp_first: got valid=%0b pc=%h instr=%h want 1 100 %h", if_valid, if_pc, if_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_ack_freeze;
        do_reset(1);
        repeat (2) @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || imem_ack !== 1'b1) begin
            n_fail++; $display("FAIL baf_pre: got valid=%0b ack=%0b want 1 1", if_valid, imem_ack);
        end
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0;
        n_checks++; if (flush !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL baf_win: got flush=%0b valid=%0b req=%0b addr=%h want 1 0 1 40", flush, if_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        n_checks++; if (flush !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem_word(32'h40)) begin
            n_fail++; $display("FAIL baf_target: got flush=%0b valid=%0b pc=%h instr=%h want 0 1 40 %h", flush, if_valid, if_pc, if_instr, mem_word(32'h40));
        end
        freeze = 1'b0;
        @(negedge clk);
        n_checks++; if (if_pc !== 32'h44) begin n_fail++; $display("FAIL baf_next: got %h want 44", if_pc); end
    endtask

    task automatic test_wrap;
        do_reset(1);
        @(negedge clk);
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC || flush !== 1'b1) begin
            n_fail++; $display("FAIL wrap_align: got addr=%h flush=%0b want fffffffc 1", imem_addr, flush);
        end
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL wrap_next: got addr=%h pc=%h want 0 fffffffc", imem_addr, if_pc);
        end
        @(negedge clk);
        n_checks++; if (if_pc !== 32'h0 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL wrap_after: got pc=%h addr=%h want 0 4", if_pc, imem_addr);
        end
    endtask

    task automatic test_reset_drain;
        int t = 0;
        do_reset(4);
        while (!(imem_req && imem_addr == 32'h8) && t < 200) begin @(negedge clk); t++; end
        branch_taken = 1'b1; branch_addr = 32'h80;
        @(negedge clk);
        branch_addr = 32'h200;
        n_checks++; if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL rd_drain1: got flush=%0b req=%0b addr=%h want 1 1 8", flush, imem_req, imem_addr);
        end
        @(negedge clk);
        branch_taken = 1'b0;
        n_checks++; if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL rd_drain2: got flush=%0b req=%0b addr=%h want 1 1 8", flush, imem_req, imem_addr);
        end
        t = 0;
        while (imem_addr == 32'h8 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rd_newer: got %h want 200", imem_addr); end
        branch_taken = 1'b1; branch_addr = 32'h300;
        @(negedge clk);
        branch_taken = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL rd_drain3: got req=%0b addr=%h want 1 200", imem_req, imem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || flush !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_reset: got req=%0b addr=%h flush=%0b valid=%0b want 0 0 0 0", imem_req, imem_addr, flush, if_valid);
        end
        rst = 1'b0;
    endtask

    // Stream scoreboard: consumed instructions must follow program order from the last redirect.
    task automatic test_random;
        logic [31:0] exp_pc = 32'h0;
        int          consumed = 0;
        logic        p_valid, p_freeze, p_branch, p_req, p_ack;
        logic [31:0] p_pc, p_instr, p_addr;
        int          m_fetch = 0;
        int          m_stall = 0;
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            freeze       = ($urandom_range(0, 9) < 3);
            spur         = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 31) == 0);
            branch_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            #1;
            p_valid = if_valid; p_freeze = freeze; p_branch = branch_taken;
            p_req = imem_req; p_ack = imem_ack; p_pc = if_pc; p_instr = if_instr; p_addr = imem_addr;
            if (p_valid && !p_freeze) m_fetch++;
            if (p_valid && p_freeze) m_stall++;
            if (p_branch) begin
                exp_pc = {branch_addr[31:2], 2'b00};
            end else if (p_valid && !p_freeze) begin
                n_checks++; if (p_pc !== exp_pc || p_instr !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_stream[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, p_pc, p_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            @(negedge clk);
            n_checks++; if (flush !== p_branch) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", i, flush, p_branch); end
            if (p_branch) begin
                n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_kill[%0d]: got valid=%0b want 0", i, if_valid); end
            end else if (p_valid && p_freeze) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== p_pc || if_instr !== p_instr) begin
                    n_fail++; $display("FAIL rnd_hold[%0d]: got valid=%0b pc=%h want 1 %h", i, if_valid, if_pc, p_pc);
                end
            end
            if (p_req && !p_ack) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    n_fail++; $display("FAIL rnd_handshake[%0d]: got req=%0b addr=%h want 1 %h", i, imem_req, imem_addr, p_addr);
                end
            end
        end
        freeze = 1'b0; branch_taken = 1'b0; spur = 1'b0;
        n_checks++; if (consumed < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed); end
`ifdef IF_FETCH_PERF_EN
        n_checks++; if (fetch_cnt !== 32'(m_fetch)) begin n_fail++; $display("FAIL perf_fetch: got %0d want %0d", fetch_cnt, m_fetch); end
        n_checks++; if (stall_cnt !== 32'(m_stall)) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, m_stall); end
`endif
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_latency;
        test_freeze_skid;
        test_branch_pending;
        test_branch_ack_freeze;
        test_wrap;
        test_reset_drain;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
